low_to_high: RTL and testbench

Width-up converter: the opposite direction of the bus splitter. It collects 2**BRUST_SIZE_LOG consecutive words from a low-width bus and packs them into one wide word. It then presents that wide word on a high-width bus and holds it until acknowledged. It sits between a narrow producer (e.g. a 32-bit peripheral port) and a wide consumer (e.g. a 128-bit memory/bus write port).

---
 rtl/low_to_high_if.sv | 33 +++
 rtl/low_to_high.sv | 85 ++++++++
 tb/tb_low_to_high.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/low_to_high_if.sv
// Narrow-producer / wide-consumer handshake bundle for the low_to_high width-up converter.
// The slave modport is the converter's view; master is the producer/consumer side.
interface low_to_high_if #(
    parameter int unsigned LOW_DATA_WIDTH = 32,
    parameter int unsigned BRUST_SIZE_LOG = 2
);
    localparam int unsigned HIGH_DATA_WIDTH = LOW_DATA_WIDTH << BRUST_SIZE_LOG;

    logic [LOW_DATA_WIDTH-1:0]  low_read_data;
    logic                       low_read_valid;
    logic                       low_read_finish;
    logic                       high_write_valid;
    logic                       high_write_finish;
    logic [HIGH_DATA_WIDTH-1:0] high_write_data;

    modport slave (
        input  low_read_data,
        input  low_read_valid,
        output low_read_finish,
        output high_write_valid,
        input  high_write_finish,
        output high_write_data
    );

    modport master (
        output low_read_data,
        output low_read_valid,
        input  low_read_finish,
        input  high_write_valid,
        output high_write_finish,
        input  high_write_data
    );
endinterface

// File: rtl/low_to_high.sv
// Width-up converter: packs 2**BRUST_SIZE_LOG low-bus words (first word in the LSBs)
// into one wide word and holds it on the high bus until the consumer acknowledges.
module low_to_high #(
    parameter int unsigned LOW_DATA_WIDTH = 32,
    parameter int unsigned BRUST_SIZE_LOG = 2
) (
    input logic           clk,
    input logic           rst_n,
    low_to_high_if.slave  bus
);
    localparam int unsigned N  = 1 << BRUST_SIZE_LOG;
    localparam int unsigned HW = LOW_DATA_WIDTH * N;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t                    state_q,  state_d;
    logic [BRUST_SIZE_LOG-1:0] cnt_q,    cnt_d;
    logic [HW-1:0]             asm_q,    asm_d;
    logic [HW-1:0]             hdata_q,  hdata_d;
    logic                      finish_q, finish_d;
    logic                      hvalid_q, hvalid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            asm_q    <= '0;
            hdata_q  <= '0;
            finish_q <= 1'b0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            hdata_q  <= hdata_d;
            finish_q <= finish_d;
            hvalid_q <= hvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        hdata_d  = hdata_q;
        finish_d = 1'b0;
        hvalid_d = hvalid_q;

        unique case (state_q)
            COLLECT: begin
                // A pending finish pulse means the producer still shows the word just taken.
                if (bus.low_read_valid && !finish_q) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        if (cnt_q == BRUST_SIZE_LOG'(k)) begin
                            asm_d[k*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] = bus.low_read_data;
                        end
                    end
                    finish_d = 1'b1;
                    if (cnt_q == '1) begin
                        cnt_d    = '0;
                        state_d  = SEND;
                        hvalid_d = 1'b1;
                        hdata_d  = asm_d;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.high_write_finish) begin
                    hvalid_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.low_read_finish  = finish_q;
    assign bus.high_write_valid = hvalid_q;
    assign bus.high_write_data  = hdata_q;
endmodule

// File: tb/tb_low_to_high.sv
// Scoreboard bench for low_to_high: a 32/2 instance and an 8/1 instance share clock and reset.
module tb_low_to_high;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    low_to_high_if #(.LOW_DATA_WIDTH(32), .BRUST_SIZE_LOG(2)) bus_a ();
    low_to_high_if #(.LOW_DATA_WIDTH(8),  .BRUST_SIZE_LOG(1)) bus_b ();

    low_to_high #(.LOW_DATA_WIDTH(32), .BRUST_SIZE_LOG(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    low_to_high #(.LOW_DATA_WIDTH(8), .BRUST_SIZE_LOG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fin_cnt_a = 0;
    int fin_cnt_b = 0;
    bit ack_a = 1'b1;
    bit ack_b = 1'b1;
    logic [127:0] qa[$];
    logic [15:0]  qb[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Consumers: acknowledge a presented wide word one cycle after it appears, when enabled.
    initial begin
        bus_a.high_write_finish = 1'b0;
        bus_b.high_write_finish = 1'b0;
        forever begin
            @(negedge clk);
            bus_a.high_write_finish = ack_a && bus_a.high_write_valid && !bus_a.high_write_finish;
            bus_b.high_write_finish = ack_b && bus_b.high_write_valid && !bus_b.high_write_finish;
        end
    end

    // Monitor: scoreboard pop on valid rise, hold stability, finish pulse shape.
    initial begin
        logic pva, pfa, pvb, pfb;
        logic [127:0] pda;
        logic [15:0]  pdb;
        pva = 0; pfa = 0; pvb = 0; pfb = 0; pda = '0; pdb = '0;
        forever begin
            @(negedge clk);
            if (bus_a.low_read_finish) begin
                fin_cnt_a++;
                check_eq("a_fin_one_cycle", pfa, 0);
            end
            if (bus_a.high_write_valid && !pva) begin
                check_eq("a_sb_nonempty", qa.size() != 0, 1);
                if (qa.size() != 0) check_eq("a_word", bus_a.high_write_data, qa.pop_front());
            end
            if (bus_a.high_write_valid && pva) begin
                check_eq("a_hold", bus_a.high_write_data, pda);
                check_eq("a_no_fin_in_send", bus_a.low_read_finish, 0);
            end
            if (bus_b.low_read_finish) begin
                fin_cnt_b++;
                check_eq("b_fin_one_cycle", pfb, 0);
            end
            if (bus_b.high_write_valid && !pvb) begin
                check_eq("b_sb_nonempty", qb.size() != 0, 1);
                if (qb.size() != 0) check_eq("b_word", bus_b.high_write_data, qb.pop_front());
            end
            if (bus_b.high_write_valid && pvb) begin
                check_eq("b_hold", bus_b.high_write_data, pdb);
                check_eq("b_no_fin_in_send", bus_b.low_read_finish, 0);
            end
            pva = bus_a.high_write_valid; pfa = bus_a.low_read_finish; pda = bus_a.high_write_data;
            pvb = bus_b.high_write_valid; pfb = bus_b.low_read_finish; pdb = bus_b.high_write_data;
        end
    end

    task automatic wait_fin_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.low_read_finish && n < 200);
        check_eq("a_fin_seen", bus_a.low_read_finish, 1);
    endtask

    task automatic put_a(input logic [31:0] w, input bit drop);
        bus_a.low_read_data  = w;
        bus_a.low_read_valid = 1'b1;
        wait_fin_a();
        if (drop) begin
            bus_a.low_read_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic put_b(input logic [7:0] w);
        int n = 0;
        bus_b.low_read_data  = w;
        bus_b.low_read_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.low_read_finish && n < 200);
        check_eq("b_fin_seen", bus_b.low_read_finish, 1);
        bus_b.low_read_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t[8];
        int f0;
        int n;
        rst_n = 1'b0;
        bus_a.low_read_valid = 1'b0; bus_a.low_read_data = '0;
        bus_b.low_read_valid = 1'b0; bus_b.low_read_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_a_fin",   bus_a.low_read_finish, 0);
            check_eq("idle_a_valid", bus_a.high_write_valid, 0);
            check_eq("idle_a_data",  bus_a.high_write_data, 0);
            check_eq("idle_b_valid", bus_b.high_write_valid, 0);
            check_eq("idle_b_data",  bus_b.high_write_data, 0);
        end

        // Single burst, producer drops valid on each finish
        qa.push_back(128'h44444444_33333333_22222222_11111111);
        f0 = fin_cnt_a;
        put_a(32'h11111111, 1);
        put_a(32'h22222222, 1);
        put_a(32'h33333333, 1);
        bus_a.low_read_data = 32'h44444444;
        bus_a.low_read_valid = 1'b1;
        wait_fin_a();
        check_eq("valid_with_last_fin", bus_a.high_write_valid, 1);
        bus_a.low_read_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("single_fin_count", fin_cnt_a - f0, 4);

        // Back-pressure: consumer stalls while a new word waits
        ack_a = 1'b0;
        qa.push_back(128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1);
        put_a(32'hC1C1C1C1, 1);
        put_a(32'hC2C2C2C2, 1);
        put_a(32'hC3C3C3C3, 1);
        put_a(32'hC4C4C4C4, 0);
        qa.push_back(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_AAAAAAAA);
        bus_a.low_read_data = 32'hAAAAAAAA;
        f0 = fin_cnt_a;
        repeat (20) @(negedge clk);
        @(negedge clk);
        check_eq("bp_no_fin", fin_cnt_a - f0, 0);
        check_eq("bp_valid_held", bus_a.high_write_valid, 1);
        ack_a = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_a.high_write_valid && n < 50);
        check_eq("bp_release", bus_a.high_write_valid, 0);
        check_eq("bp_no_cap_on_ack", bus_a.low_read_finish, 0);
        @(negedge clk);
        check_eq("bp_slot0_fin", bus_a.low_read_finish, 1);
        bus_a.low_read_valid = 1'b0;
        @(negedge clk);
        put_a(32'hB1B1B1B1, 1);
        put_a(32'hB2B2B2B2, 1);
        put_a(32'hB3B3B3B3, 1);
        repeat (4) @(negedge clk);

        // Held valid: data changes on each finish, two bursts back to back
        qa.push_back(128'hD0000003_D0000002_D0000001_D0000000);
        qa.push_back(128'hD0000007_D0000006_D0000005_D0000004);
        for (int i = 0; i < 8; i++) begin
            put_a(32'hD0000000 + 32'(i), 0);
            t[i] = cyc;
        end
        bus_a.low_read_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (i != 4) check_eq("held_gap", t[i] - t[i-1], 2);
        end
        check_eq("held_xburst_gap", (t[4] - t[3]) >= 2, 1);
        repeat (4) @(negedge clk);

        // Reset mid-burst discards the partial words
        put_a(32'hE1E1E1E1, 1);
        put_a(32'hE2E2E2E2, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_fin",   bus_a.low_read_finish, 0);
        check_eq("rst_valid", bus_a.high_write_valid, 0);
        qa.push_back(128'h00000008_00000007_00000006_00000005);
        for (int i = 5; i <= 8; i++) put_a(32'(i), 1);
        repeat (4) @(negedge clk);

        // Narrow instance: three bursts exercise the counter wrap
        for (int b = 0; b < 3; b++) begin
            qb.push_back(16'hCDAB);
            put_b(8'hAB);
            put_b(8'hCD);
            check_eq("b_valid_with_last", bus_b.high_write_valid, 1);
            repeat (3) @(negedge clk);
        end
        check_eq("b_fin_count", fin_cnt_b, 6);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drained", qa.size() + qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
